// File: rtl/mul_div_ctrl_if.sv
// ============================================================================
// Module   : mul_div_ctrl_if
// Brief    : Request/result bundle between mul_div_ctrl and the mul_div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_div_ctrl_if;
   logic        mul_div_req_o;
   logic [2:0]  m_d_op_o;
   logic [6:0]  op_o;
   logic [31:0] rs1_o;
   logic [31:0] rs2_o;
   logic        rs1_signed_o;
   logic        rs2_signed_o;
   logic [31:0] high_i;
   logic [31:0] low_i;
   logic        ready_i;

   modport master (
      output mul_div_req_o, m_d_op_o, op_o, rs1_o, rs2_o, rs1_signed_o, rs2_signed_o,
      input  high_i, low_i, ready_i
   );

   modport slave (
      input  mul_div_req_o, m_d_op_o, op_o, rs1_o, rs2_o, rs1_signed_o, rs2_signed_o,
      output high_i, low_i, ready_i
   );
endinterface

`default_nettype wire

// File: rtl/mul_div_ctrl.sv
// ============================================================================
// Module   : mul_div_ctrl
// Brief    : EXE-stage RV32M initiator for the iterative mul_div unit with
//            RV32M corner-case fixes. Optional result cache: MUL_DIV_RESULT_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_ctrl #(
   parameter logic [6:0] OP_R_M   = 7'b0110011,
   parameter int         MAX_WAIT = 40
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic [2:0]      funct3_i,
   input  logic [31:0]     rs1_i,
   input  logic [31:0]     rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            wb_valid_o,
   output logic [31:0]     wb_data_o,
   output logic [4:0]      wb_rd_o,
   output logic            timeout_o,
   mul_div_ctrl_if.master  md
);
   localparam int c_WD_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [c_WD_W-1:0] r_wdog;
   logic [4:0]        r_rd;
   logic              w_accept;
   logic              w_capture;
   logic              w_timeout;
   logic              w_hit;
   logic [31:0]       w_hit_hi;
   logic [31:0]       w_hit_lo;

   function automatic logic f_rs1_signed(input logic [2:0] f3);
      return (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
   endfunction

   function automatic logic f_rs2_signed(input logic [2:0] f3);
      return (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
   endfunction

   // Divider reports |remainder| in hi, so signed REM must restore the dividend's sign
   function automatic logic [31:0] f_result(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
      logic [31:0] res;
      res = (f3 == 3'd0) ? lo : hi;
      if (f3[2]) begin
         if (b == '0)
            res = f3[1] ? a : '1;
         else if ((f3 == 3'd4) && (a == 32'h8000_0000) && (b == '1))
            res = 32'h8000_0000;
         else if ((f3 == 3'd6) && (a == 32'h8000_0000) && (b == '1))
            res = '0;
         else if ((f3 == 3'd6) && a[31])
            res = -hi;
         else
            res = f3[1] ? hi : lo;
      end
      return res;
   endfunction

   assign w_accept  = (r_state == ST_IDLE) && req_i && !flush_i;
   assign w_capture = (r_state == ST_BUSY) && !flush_i && md.ready_i;
   assign w_timeout = (r_state == ST_BUSY) && !flush_i && !md.ready_i &&
                      (r_wdog == c_WD_W'(MAX_WAIT));
   assign stall_o   = (r_state == ST_BUSY) || ((r_state == ST_IDLE) && req_i);

`ifdef MUL_DIV_RESULT_CACHE_EN
   logic        r_c_vld;
   logic [31:0] r_c_rs1;
   logic [31:0] r_c_rs2;
   logic [31:0] r_c_hi;
   logic [31:0] r_c_lo;
   logic [1:0]  r_c_sgn;
   logic        r_c_div;
   logic [1:0]  w_sgn_in;

   assign w_sgn_in = {f_rs1_signed(funct3_i), f_rs2_signed(funct3_i)};
   // MUL only consumes lo, which is the same for every signedness pair
   assign w_hit    = r_c_vld && (rs1_i == r_c_rs1) && (rs2_i == r_c_rs2) &&
                     (funct3_i[2] == r_c_div) &&
                     ((funct3_i == 3'd0) || (w_sgn_in == r_c_sgn));
   assign w_hit_hi = r_c_hi;
   assign w_hit_lo = r_c_lo;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_c_vld <= 1'b0;
         r_c_rs1 <= '0;
         r_c_rs2 <= '0;
         r_c_hi  <= '0;
         r_c_lo  <= '0;
         r_c_sgn <= '0;
         r_c_div <= 1'b0;
      end else if (w_timeout) begin
         r_c_vld <= 1'b0;
      end else if (w_capture) begin
         r_c_vld <= 1'b1;
         r_c_rs1 <= md.rs1_o;
         r_c_rs2 <= md.rs2_o;
         r_c_hi  <= md.high_i;
         r_c_lo  <= md.low_i;
         r_c_sgn <= {md.rs1_signed_o, md.rs2_signed_o};
         r_c_div <= md.m_d_op_o[2];
      end
   end
`else
   assign w_hit    = 1'b0;
   assign w_hit_hi = '0;
   assign w_hit_lo = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state         <= ST_IDLE;
         r_wdog          <= '0;
         r_rd            <= '0;
         wb_valid_o      <= 1'b0;
         wb_data_o       <= '0;
         wb_rd_o         <= '0;
         timeout_o       <= 1'b0;
         md.mul_div_req_o <= 1'b0;
         md.m_d_op_o     <= '0;
         md.op_o         <= '0;
         md.rs1_o        <= '0;
         md.rs2_o        <= '0;
         md.rs1_signed_o <= 1'b0;
         md.rs2_signed_o <= 1'b0;
      end else begin
         wb_valid_o <= 1'b0;
         timeout_o  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  md.m_d_op_o     <= funct3_i;
                  md.rs1_o        <= rs1_i;
                  md.rs2_o        <= rs2_i;
                  md.rs1_signed_o <= f_rs1_signed(funct3_i);
                  md.rs2_signed_o <= f_rs2_signed(funct3_i);
                  r_rd            <= rd_i;
                  r_wdog          <= '0;
                  if (w_hit) begin
                     r_state    <= ST_DONE;
                     wb_valid_o <= 1'b1;
                     wb_data_o  <= f_result(funct3_i, rs1_i, rs2_i, w_hit_hi, w_hit_lo);
                     wb_rd_o    <= rd_i;
                  end else begin
                     r_state          <= ST_BUSY;
                     md.mul_div_req_o <= 1'b1;
                     md.op_o          <= OP_R_M;
                  end
               end
            end
            ST_BUSY: begin
               r_wdog <= r_wdog + c_WD_W'(1);
               if (flush_i) begin
                  r_state          <= ST_IDLE;
                  md.mul_div_req_o <= 1'b0;
                  md.op_o          <= '0;
               end else if (w_capture) begin
                  r_state          <= ST_DONE;
                  md.mul_div_req_o <= 1'b0;
                  md.op_o          <= '0;
                  wb_valid_o       <= 1'b1;
                  wb_data_o        <= f_result(md.m_d_op_o, md.rs1_o, md.rs2_o,
                                               md.high_i, md.low_i);
                  wb_rd_o          <= r_rd;
               end else if (w_timeout) begin
                  r_state          <= ST_DONE;
                  md.mul_div_req_o <= 1'b0;
                  md.op_o          <= '0;
                  wb_valid_o       <= 1'b1;
                  wb_data_o        <= '0;
                  wb_rd_o          <= r_rd;
                  timeout_o        <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_mul_div_ctrl.sv
// ============================================================================
// Module   : tb_mul_div_ctrl
// Brief    : Self-checking bench for mul_div_ctrl with a behavioural mul_div unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_ctrl;
   localparam int         MAX_WAIT = 40;
   localparam logic [6:0] OP_R_M   = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst_i, req_i, flush_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i, rs2_i;
   logic [4:0]  rd_i;
   logic        stall_o, wb_valid_o, timeout_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;

   mul_div_ctrl_if md_if ();

   mul_div_ctrl #(.OP_R_M(OP_R_M), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .funct3_i(funct3_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
      .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
      .wb_rd_o(wb_rd_o), .timeout_o(timeout_o), .md(md_if)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Architectural RV32M result, straight from the ISA rules
   function automatic logic [31:0] ref_rv32m(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, t;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'({32'h0, b})); return p[63:32]; end
         3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
         3'd4: begin if (b == 0) return '1; t = sa / sb; return t[31:0]; end
         3'd5: begin if (b == 0) return '1; return a / b; end
         3'd6: begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   // mul_div unit: {hi,lo} product, or {|remainder|, quotient}; garbage on /0
   function automatic logic [63:0] md_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!f[2]) begin
         if (f == 3'd1)      p = 64'(sa * sb);
         else if (f == 3'd2) p = 64'(sa * longint'({32'h0, b}));
         else                p = {32'h0, a} * {32'h0, b};
      end else if (b == 0) begin
         p = 64'h1234_5678_DEAD_BEEF;
      end else if (f[0]) begin
         p = {a % b, a / b};
      end else begin
         q = sa / sb;
         r = sa % sb;
         if (r < 0) r = -r;
         p = {r[31:0], q[31:0]};
      end
      return p;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic give_ready(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] hl;
      hl = md_model(f, a, b);
      md_if.ready_i = 1'b1;
      md_if.high_i  = hl[63:32];
      md_if.low_i   = hl[31:0];
   endtask

   task automatic drop_ready();
      md_if.ready_i = 1'b0;
      md_if.high_i  = 32'($urandom);
      md_if.low_i   = 32'($urandom);
   endtask

   // lat = BUSY cycle (1-based) in which the unit raises ready_i
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input logic [31:0] exp);
      logic s1, s2;
      s1 = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
      s2 = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
      @(negedge clk);
      req_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b; rd_i = rd;
      #1 chk("stall_req", 64'(stall_o), 64'd1);
      @(negedge clk);
      req_i = 1'b0; funct3_i = 3'($urandom); rs1_i = 32'($urandom); rs2_i = 32'($urandom);
      rd_i = 5'($urandom);
      #1 chk("md_req", 64'({md_if.mul_div_req_o, md_if.op_o, md_if.m_d_op_o,
                            md_if.rs1_signed_o, md_if.rs2_signed_o}),
                       64'({1'b1, OP_R_M, f, s1, s2}));
      chk("md_ops", {md_if.rs1_o, md_if.rs2_o}, {a, b});
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         chk("stall_busy", 64'({stall_o, wb_valid_o}), 64'd2);
      end
      give_ready(f, a, b);
      @(negedge clk);
      drop_ready();
      #1 chk("wb_valid", 64'(wb_valid_o), 64'd1);
      chk("wb_data", 64'(wb_data_o), 64'(exp));
      chk("wb_rd", 64'(wb_rd_o), 64'(rd));
      chk("done_ctl", 64'({stall_o, md_if.mul_div_req_o, md_if.op_o, timeout_o}), 64'd0);
      @(negedge clk);
      chk("wb_pulse", 64'(wb_valid_o), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int seen;
      logic [2:0]  f;
      logic [31:0] a, b;

      vt[0]  = '{f: 3'd0, a: 32'd7,          b: 32'hFFFF_FFFD, exp: 32'hFFFF_FFEB};
      vt[1]  = '{f: 3'd3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFE};
      vt[2]  = '{f: 3'd1, a: 32'h8000_0000, b: 32'h8000_0000, exp: 32'h4000_0000};
      vt[3]  = '{f: 3'd4, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 32'hFFFF_FFFD};
      vt[4]  = '{f: 3'd6, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 32'hFFFF_FFFF};
      vt[5]  = '{f: 3'd5, a: 32'd5,          b: 32'd0,          exp: 32'hFFFF_FFFF};
      vt[6]  = '{f: 3'd7, a: 32'd5,          b: 32'd0,          exp: 32'd5};
      vt[7]  = '{f: 3'd4, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'h8000_0000};
      vt[8]  = '{f: 3'd6, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 32'd0};
      vt[9]  = '{f: 3'd0, a: 32'd0,          b: 32'h1234,       exp: 32'd0};
      vt[10] = '{f: 3'd2, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
      vt[11] = '{f: 3'd6, a: 32'hFFFF_FFFB, b: 32'd0,          exp: 32'hFFFF_FFFB};

      rst_i = 1'b1; req_i = 1'b0; flush_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
      rd_i = '0; md_if.ready_i = 1'b0; md_if.high_i = '0; md_if.low_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_out", 64'({stall_o, wb_valid_o, wb_data_o, wb_rd_o, timeout_o}), 64'd0);
      chk("rst_md", 64'({md_if.mul_div_req_o, md_if.op_o, md_if.m_d_op_o,
                         md_if.rs1_signed_o, md_if.rs2_signed_o}), 64'd0);
      chk("rst_ops", {md_if.rs1_o, md_if.rs2_o}, 64'd0);
      rst_i = 1'b0;

      foreach (vt[i])
         run_op(vt[i].f, vt[i].a, vt[i].b, 5'(i + 1),
                (vt[i].a == 0 || vt[i].b == 0) ? 2 : 5, vt[i].exp);

      for (int n = 0; n < 40; n++) begin
         f = 3'($urandom_range(0, 7));
         a = rnd_opnd();
         b = rnd_opnd();
         run_op(f, a, b, 5'($urandom), (a == 0 || b == 0) ? 2 : int'($urandom_range(1, 36)),
                ref_rv32m(f, a, b));
      end

      // ready_i while idle must be ignored
      @(negedge clk);
      give_ready(3'd0, 32'd3, 32'd3);
      @(negedge clk);
      drop_ready();
      #1 chk("ready_idle", 64'({wb_valid_o, md_if.mul_div_req_o}), 64'd0);

      // flush beats a simultaneous request
      @(negedge clk);
      req_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; rs1_i = 32'd2; rs2_i = 32'd2;
      @(negedge clk);
      req_i = 1'b0; flush_i = 1'b0;
      #1 chk("flush_idle", 64'({md_if.mul_div_req_o, stall_o}), 64'd0);

      // flush ten cycles into a DIV
      @(negedge clk);
      req_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd4;
      @(negedge clk);
      req_i = 1'b0;
      repeat (9) @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      #1 chk("flush_busy", 64'({md_if.mul_div_req_o, stall_o, wb_valid_o}), 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("flush_nowb", 64'(wb_valid_o), 64'd0);
      end
      run_op(3'd0, 32'd6, 32'd7, 5'd5, 3, 32'd42);

      // a request held through DONE is only taken in the next IDLE cycle
      @(negedge clk);
      req_i = 1'b1; funct3_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd3;
      @(negedge clk);
      give_ready(3'd5, 32'd100, 32'd7);
      funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd4; rd_i = 5'd9;
      @(negedge clk);
      drop_ready();
      #1 chk("b2b_done", 64'({wb_valid_o, wb_data_o}), 64'({1'b1, 32'd14}));
      @(negedge clk);
      chk("b2b_no_acc", 64'({md_if.mul_div_req_o, stall_o}), 64'd1);
      @(negedge clk);
      req_i = 1'b0;
      #1 chk("b2b_acc", 64'(md_if.mul_div_req_o), 64'd1);
      give_ready(3'd0, 32'd3, 32'd4);
      @(negedge clk);
      drop_ready();
      #1 chk("b2b_wb", 64'({wb_valid_o, wb_rd_o, wb_data_o}), 64'({1'b1, 5'd9, 32'd12}));

      // watchdog with ready_i held low
      @(negedge clk);
      req_i = 1'b1; funct3_i = 3'd4; rs1_i = 32'd9; rs2_i = 32'd3; rd_i = 5'd7;
      @(negedge clk);
      req_i = 1'b0;
      seen = 0;
      for (int n = 1; n <= MAX_WAIT + 10; n++) begin
         @(negedge clk);
         if (timeout_o) begin
            seen = n;
            break;
         end
      end
      chk("timeout_time", 64'(seen >= MAX_WAIT && seen <= MAX_WAIT + 2), 64'd1);
      chk("timeout_wb", 64'({wb_valid_o, wb_rd_o, wb_data_o}), 64'({1'b1, 5'd7, 32'd0}));
      @(negedge clk);
      chk("timeout_pulse", 64'({timeout_o, wb_valid_o, md_if.mul_div_req_o}), 64'd0);

      // reset in the middle of an operation
      @(negedge clk);
      req_i = 1'b1; funct3_i = 3'd1; rs1_i = 32'd11; rs2_i = 32'd13; rd_i = 5'd8;
      @(negedge clk);
      req_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      #1 chk("rst_mid", 64'({md_if.mul_div_req_o, md_if.op_o, stall_o, wb_valid_o, timeout_o}),
                        64'd0);
      give_ready(3'd1, 32'd11, 32'd13);
      @(negedge clk);
      drop_ready();
      #1 chk("rst_nowb", 64'(wb_valid_o), 64'd0);
      run_op(3'd6, 32'hFFFF_FFEC, 32'd6, 5'd31, 4, 32'hFFFF_FFFE);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

`default_nettype wire
